cmp_sequencer: RTL and testbench
================================

# cmp_sequencer

Byte-serial equality sequencer that shares one 8-bit equality unit (`checkequal`) between two requesters. Operands are `8*NBYTES` bits wide.
- A round-robin arbiter accepts a compare request from one of the two requesters.
- The block walks the operand bytes LSB-first through the single comparator and exits early on the first mismatching byte.
- It returns equal/mismatch, the index of the first mismatching byte, and the ID of the served requester over a valid/ready response port.
- It sits between the ALU issue logic and the compare datapath, so wide compares reuse the 8-bit unit instead of a wide comparator.

## Interface
- `NBYTES`, default 4: operand width in bytes. Legal range is 1..16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a compare pending.
- `req0_a` in `8*NBYTES`: requester 0 operand A.
- `req0_b` in `8*NBYTES`: requester 0 operand B.
- `req0_ready` out 1: requester 0 accepted when `req0_valid && req0_ready` at a clock edge.
- `req1_valid` in 1: as for requester 0.
- `req1_a` in `8*NBYTES`: as for requester 0.
- `req1_b` in `8*NBYTES`: as for requester 0.
- `req1_ready` out 1: as for requester 0.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes the response when `rsp_valid && rsp_ready` at a clock edge.
- `rsp_equal` out 1: 1 = all bytes equal.
- `rsp_idx` out 4: index of the first mismatching byte; 0 when `rsp_equal` = 1.
- `rsp_id` out 1: requester served (0 or 1).

## Operation
- The FSM has three states: IDLE, COMPARE and RESP.
- **IDLE:**
  - The grant is computed combinationally from the two valid inputs.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not served last is granted (`last` register).
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is ever high.
  - On handshake, capture A, B and the grant ID, set `byte_idx` = 0, update `last` to the grant, and go to COMPARE.
- **COMPARE:**
  - Each cycle, byte `byte_idx` of A and B is applied to the single `checkequal` instance.
  - Mismatch: register `rsp_equal` = 0 and `rsp_idx` = `byte_idx`, then go to RESP.
  - Match with `byte_idx` == NBYTES-1: register `rsp_equal` = 1 and `rsp_idx` = 0, then go to RESP.
  - Match otherwise: increment `byte_idx`.
- **RESP:**
  - `rsp_valid` = 1 and response fields stay stable until the response handshake.
  - On handshake, go to IDLE.
  - No request is accepted in RESP.
- Captured operands are held internally; requester inputs may change after their handshake.
- Reset mid-operation aborts the transaction. No response is produced and the captured data is discarded.

## Timing
- Values forced while `rst_n` = 0:
  - State = IDLE.
  - `rsp_valid`, `rsp_equal`, `rsp_idx` and `rsp_id` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - Both readies = 0.
- Readies are valid from the first cycle after reset deassertion.
- Latency: request handshake at edge E0. Byte j is compared between edges Ej and Ej+1.
  - `rsp_valid` rises after edge E(k+1), where k is the first mismatching byte, or NBYTES-1 if all bytes are equal.
  - Minimum latency is 1 cycle; maximum is NBYTES cycles.
- Response and IDLE:
  - The response handshake at edge R returns the FSM to IDLE.
  - The earliest next request acceptance is edge R+1.
  - Back-to-back throughput is one compare per (k+1) + 2 cycles.
- `rsp_ready` held 0 stalls in RESP indefinitely. Requests wait; none are dropped.
- `rsp_ready` high before `rsp_valid` has no effect.
- Readies may depend combinationally on valids. Valids must not depend on readies.
- A requester deasserting valid before its handshake is legal; the grant re-evaluates every IDLE cycle.

## Test plan
- **Single equal compare:** NBYTES = 4, `req0` A = B = 0xDEADBEEF.
  - `req0_ready` is 1 in the same cycle.
  - `rsp_valid` appears 4 cycles after accept with `rsp_equal` = 1, `rsp_idx` = 0, `rsp_id` = 0.
- **Early-exit mismatch:** `req1` A = 0x11223344, B = 0x11993344.
  - Response 3 cycles after accept with `rsp_equal` = 0, `rsp_idx` = 2, `rsp_id` = 1.
- **Byte-0 mismatch:** A = 0x000000FF, B = 0x00000000.
  - Response 1 cycle after accept with `rsp_idx` = 0, `rsp_equal` = 0.
- **Round-robin tie:** both valid continuously after reset.
  - Served order is 0, 1, 0, 1 over four transactions.
  - `rsp_id` matches each served requester.
  - Only one ready is high in any cycle.
- **Backpressure:** hold `rsp_ready` = 0 for 10 cycles after `rsp_valid`.
  - `rsp_valid`, `rsp_equal`, `rsp_idx` and `rsp_id` stay stable.
  - Both readies stay 0.
  - After `rsp_ready` = 1, the next accept occurs exactly 1 cycle after the response handshake.
- **Reset mid-compare:** assert `rst_n` = 0 during byte 1 of an equal 4-byte compare.
  - All outputs go to 0 asynchronously.
  - No response follows after release.
  - The next tie is won by requester 0.

Source files
------------

// File: rtl/cmp_sequencer.sv
// cmp_sequencer: byte-serial equality sequencer.
// Two requesters share one 8-bit checkequal unit; bytes are walked LSB-first.

module checkequal (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       eq
);
    assign eq = (a == b);
endmodule

module cmp_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_equal,
    output logic [3:0]            rsp_idx,
    output logic                  rsp_id
);
    localparam int W = 8 * NBYTES;
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        RESP
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [3:0]   byte_idx_q, byte_idx_d;
    logic         last_q, last_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_equal_q, rsp_equal_d;
    logic [3:0]   rsp_idx_q, rsp_idx_d;
    logic         rsp_id_q, rsp_id_d;

    logic         any_valid;
    logic         grant;
    logic         idle;
    logic         accept;
    logic [W-1:0] a_sh;
    logic [W-1:0] b_sh;
    logic         byte_eq;

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
    end

    // Readies are gated by rst_n so they read 0 throughout reset.
    assign idle       = (state_q == IDLE);
    assign req0_ready = rst_n && idle && any_valid && !grant;
    assign req1_ready = rst_n && idle && any_valid && grant;
    assign accept     = req0_ready | req1_ready;

    assign a_sh = a_q >> {byte_idx_q, 3'b000};
    assign b_sh = b_q >> {byte_idx_q, 3'b000};

    checkequal u_checkequal (
        .a  (a_sh[7:0]),
        .b  (b_sh[7:0]),
        .eq (byte_eq)
    );

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        byte_idx_d  = byte_idx_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_equal_d = rsp_equal_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d        = grant ? req1_a : req0_a;
                    b_d        = grant ? req1_b : req0_b;
                    rsp_id_d   = grant;
                    last_d     = grant;
                    byte_idx_d = 4'd0;
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                if (!byte_eq) begin
                    rsp_valid_d = 1'b1;
                    rsp_equal_d = 1'b0;
                    rsp_idx_d   = byte_idx_q;
                    state_d     = RESP;
                end else if (byte_idx_q == LAST_IDX) begin
                    rsp_valid_d = 1'b1;
                    rsp_equal_d = 1'b1;
                    rsp_idx_d   = 4'd0;
                    state_d     = RESP;
                end else begin
                    byte_idx_d = byte_idx_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            byte_idx_q  <= 4'd0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_equal_q <= 1'b0;
            rsp_idx_q   <= 4'd0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            byte_idx_q  <= byte_idx_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_equal_q <= rsp_equal_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_equal = rsp_equal_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cmp_sequencer.sv
// tb_cmp_sequencer: directed bench for cmp_sequencer.
// Expected responses come from a reference model through a scoreboard queue.

module tb_cmp_sequencer;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_equal;
    logic [3:0]   rsp_idx;
    logic         rsp_id;

    cmp_sequencer #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_equal  (rsp_equal),
        .rsp_idx    (rsp_idx),
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       eq;
        logic [3:0] idx;
        logic       id;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest mismatching byte wins; latency is that index plus one.
    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic id);
        exp_t e;
        e.eq  = 1'b1;
        e.idx = 4'd0;
        e.id  = id;
        e.lat = NB;
        for (int i = NB - 1; i >= 0; i--) begin
            if (a[8*i +: 8] != b[8*i +: 8]) begin
                e.eq  = 1'b0;
                e.idx = 4'(i);
                e.lat = i + 1;
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic send(input logic id, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        if (id) begin
            req1_valid = 1'b1;
            req1_a     = a;
            req1_b     = b;
        end else begin
            req0_valid = 1'b1;
            req0_a     = a;
            req0_b     = b;
        end
        #1;
        check(id ? "ready1_same_cycle" : "ready0_same_cycle",
              id ? req1_ready : req0_ready, 1);
        check("other_ready_low", id ? req0_ready : req1_ready, 0);
        sb.push_back(model(a, b, id));
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Waits for the response, checks it against the scoreboard, optionally
    // stalls, then completes the handshake. Returns at the negedge after it.
    task automatic get_rsp(input string tag, input int stall);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, cnt, e.lat);
            check({tag, "_equal"}, rsp_equal, e.eq);
            check({tag, "_idx"}, rsp_idx, e.idx);
            check({tag, "_id"}, rsp_id, e.id);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, "_stall_valid"}, rsp_valid, 1);
                check({tag, "_stall_equal"}, rsp_equal, e.eq);
                check({tag, "_stall_idx"}, rsp_idx, e.idx);
                check({tag, "_stall_id"}, rsp_id, e.id);
                check({tag, "_stall_readies"}, {req0_ready, req1_ready}, 0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, "_rsp_cleared"}, rsp_valid, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   served;
        int   got;
        int   cyc;

        // Reset state with both requesters asserting valid.
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        #12;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_equal", rsp_equal, 0);
        check("rst_rsp_idx", rsp_idx, 0);
        check("rst_rsp_id", rsp_id, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single equal compare, early-exit mismatch, byte-0 mismatch.
        send(1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
        get_rsp("eq4", 0);
        send(1'b1, 32'h11223344, 32'h11993344);
        get_rsp("mm2", 0);
        send(1'b0, 32'h000000FF, 32'h00000000);
        get_rsp("mm0", 0);

        // Round-robin tie with both valid continuously after reset.
        do_reset();
        req0_a     = 32'h01020304;
        req0_b     = 32'h01020304;
        req1_a     = 32'hAAAA0055;
        req1_b     = 32'hAAAA1155;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        served = 0;
        got    = 0;
        cyc    = 0;
        while (got < 4 && cyc < 200) begin
            #1;
            check("rr_one_hot_ready", {31'd0, req0_ready & req1_ready}, 0);
            if (req0_ready || req1_ready) begin
                check("rr_order", req1_ready, served % 2);
                if (req1_ready) sb.push_back(model(req1_a, req1_b, 1'b1));
                else            sb.push_back(model(req0_a, req0_b, 1'b0));
                served++;
            end
            if (rsp_valid) begin
                check("rr_sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rr_id", rsp_id, e.id);
                    check("rr_equal", rsp_equal, e.eq);
                    check("rr_idx", rsp_idx, e.idx);
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        check("rr_responses", got, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);

        // Backpressure with a pending request from requester 1.
        send(1'b0, 32'h12345678, 32'h12005678);
        req1_a     = 32'h0BADF00D;
        req1_b     = 32'h0BADF00D;
        req1_valid = 1'b1;
        get_rsp("bp", 10);
        #1;
        check("bp_next_accept_ready", req1_ready, 1);
        sb.push_back(model(req1_a, req1_b, 1'b1));
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("bp_accepted", req1_ready, 0);
        get_rsp("bp_next", 0);

        // Reset during byte 1 of an equal 4-byte compare.
        do_reset();
        send(1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n      = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_req0_ready", req0_ready, 0);
        check("mid_rst_req1_ready", req1_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_equal", rsp_equal, 0);
        check("mid_rst_rsp_idx", rsp_idx, 0);
        check("mid_rst_rsp_id", rsp_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_tie_req0", req0_ready, 1);
        check("post_rst_tie_req1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
